// File: rtl/uart_ram_tft_pkg.sv
// Shared timing constants, RX state encoding and pixel helpers for uart_ram_tft.
// Panel timing is the fixed 640x480 mode (800x525 totals in pixel clocks).
package uart_ram_tft_pkg;

    localparam int unsigned HSync   = 96;
    localparam int unsigned HBack   = 48;
    localparam int unsigned HActive = 640;
    localparam int unsigned HFront  = 16;
    localparam int unsigned HTotal  = HSync + HBack + HActive + HFront;
    localparam int unsigned HStart  = HSync + HBack;

    localparam int unsigned VSync   = 2;
    localparam int unsigned VBack   = 33;
    localparam int unsigned VActive = 480;
    localparam int unsigned VFront  = 10;
    localparam int unsigned VTotal  = VSync + VBack + VActive + VFront;
    localparam int unsigned VStart  = VSync + VBack;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

    // RRRGGGBB -> RGB565, replicating MSBs so full-scale stays full-scale.
    function automatic logic [15:0] rgb332_to_565(input logic [7:0] p);
        return {p[7:5], p[7:6], p[4:2], p[4:2], p[1:0], p[1:0], p[1]};
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle valid strobe.
// Bytes with a bad stop bit are dropped silently.
module uart_byte_rx
    import uart_ram_tft_pkg::*;
#(
    parameter int unsigned ClksPerBit = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid
);

    localparam int unsigned CntW = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] CntBitEnd  = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] CntHalfEnd = CntW'(ClksPerBit / 2 - 1);

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    uart_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Edge, not level: a line still low after a framing error must not restart.
                if (rx_prev_q && !rx_sync_q) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == CntHalfEnd) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_sync_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntBitEnd) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (idx_q == 3'd7) state_d = StStop;
                    else               idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CntBitEnd) begin
                    cnt_d   = '0;
                    valid_d = rx_sync_q;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data  = shift_q;
    assign valid = valid_q;

endmodule

// File: rtl/uart_ram_tft.sv
// UART-fed RGB332 framebuffer scanned out to a 640x480 RGB565 TFT at Clk/2.
// Define TFT_TEST_PATTERN_EN to fill pixels outside the image with 8 colour bars.
module uart_ram_tft
    import uart_ram_tft_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned IMG_W    = 128,
    parameter int unsigned IMG_H    = 128,
    parameter int unsigned IMG_X    = 0,
    parameter int unsigned IMG_Y    = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        uart_rx,
    output logic [15:0] TFT_RGB,
    output logic        TFT_HS,
    output logic        TFT_VS,
    output logic        TFT_DE,
    output logic        TFT_CLK,
    output logic        TFT_BL
);

    localparam int unsigned ImgPix = IMG_W * IMG_H;
    localparam int unsigned AddrW  = (ImgPix > 1) ? $clog2(ImgPix) : 1;

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [AddrW-1:0] waddr_q, raddr;
    logic [7:0]       ram [ImgPix];
    logic [7:0]       rdata_q;

    logic        pe_q, tclk_q, bl_q, hs_q, vs_q, de_q;
    logic [15:0] rgb_q;
    logic [9:0]  hcnt_q, vcnt_q;
    logic [9:0]  x, y;
    logic [10:0] dx, dy;
    logic        active, in_img;
    logic [15:0] bg, pix;

    uart_byte_rx #(
        .ClksPerBit(CLK_FREQ / BAUD)
    ) u_rx (
        .clk  (Clk),
        .rst  (Reset),
        .rx   (uart_rx),
        .data (rx_data),
        .valid(rx_valid)
    );

    always_ff @(posedge Clk) begin
        if (Reset)         waddr_q <= '0;
        else if (rx_valid) waddr_q <= (waddr_q == AddrW'(ImgPix - 1)) ? '0 : waddr_q + 1'b1;
    end

    // Frame RAM is never reset; a same-address read/write returns the old byte.
    always_ff @(posedge Clk) begin
        if (rx_valid && !Reset) ram[waddr_q] <= rx_data;
        if (!pe_q)              rdata_q      <= ram[raddr];
    end

    always_comb begin
        x      = hcnt_q - 10'(HStart);
        y      = vcnt_q - 10'(VStart);
        active = (hcnt_q >= 10'(HStart)) && (hcnt_q < 10'(HStart + HActive)) &&
                 (vcnt_q >= 10'(VStart)) && (vcnt_q < 10'(VStart + VActive));
        // Extra MSB acts as a borrow flag for coordinates left of / above the window.
        dx     = {1'b0, x} - 11'(IMG_X);
        dy     = {1'b0, y} - 11'(IMG_Y);
        in_img = active && !dx[10] && (dx[9:0] < 10'(IMG_W)) &&
                 !dy[10] && (dy[9:0] < 10'(IMG_H));
        raddr  = in_img ? AddrW'(32'(dy[9:0]) * IMG_W + 32'(dx[9:0])) : '0;
`ifdef TFT_TEST_PATTERN_EN
        bg     = bar_color(3'(x / 10'd80));
`else
        bg     = 16'h0000;
`endif
        pix    = !active ? 16'h0000 : (in_img ? rgb332_to_565(rdata_q) : bg);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pe_q   <= 1'b0;
            tclk_q <= 1'b0;
            bl_q   <= 1'b0;
            rgb_q  <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            de_q   <= 1'b0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            pe_q   <= ~pe_q;
            tclk_q <= ~pe_q;
            bl_q   <= 1'b1;
            if (pe_q) begin
                rgb_q <= pix;
                hs_q  <= !(hcnt_q < 10'(HSync));
                vs_q  <= !(vcnt_q < 10'(VSync));
                de_q  <= active;
                if (hcnt_q == 10'(HTotal - 1)) begin
                    hcnt_q <= '0;
                    vcnt_q <= (vcnt_q == 10'(VTotal - 1)) ? '0 : vcnt_q + 1'b1;
                end else begin
                    hcnt_q <= hcnt_q + 1'b1;
                end
            end
        end
    end

    assign TFT_RGB = rgb_q;
    assign TFT_HS  = hs_q;
    assign TFT_VS  = vs_q;
    assign TFT_DE  = de_q;
    assign TFT_CLK = tclk_q;
    assign TFT_BL  = bl_q;

endmodule

// File: tb/tb_uart_ram_tft.sv
// Directed bench for uart_ram_tft: 16-clock UART bits, 4x4 image so the write pointer wraps
// and the first frame's first active lines can be inspected.
module tb_uart_ram_tft;

    localparam int unsigned Bit = 16;

`ifdef TFT_TEST_PATTERN_EN
    localparam logic [15:0] BgX4   = 16'hFFFF;
    localparam logic [15:0] BgX100 = 16'hFFE0;
`else
    localparam logic [15:0] BgX4   = 16'h0000;
    localparam logic [15:0] BgX100 = 16'h0000;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic [15:0] TFT_RGB;
    logic        TFT_HS, TFT_VS, TFT_DE, TFT_CLK, TFT_BL;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_ram_tft #(
        .CLK_FREQ(1_600_000),
        .BAUD    (100_000),
        .IMG_W   (4),
        .IMG_H   (4),
        .IMG_X   (0),
        .IMG_Y   (0)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .uart_rx(uart_rx),
        .TFT_RGB(TFT_RGB),
        .TFT_HS (TFT_HS),
        .TFT_VS (TFT_VS),
        .TFT_DE (TFT_DE),
        .TFT_CLK(TFT_CLK),
        .TFT_BL (TFT_BL)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    logic hs_p = 1'b1, vs_p = 1'b1;
    int hs_fall_t = 0, hs_low = 0, hs_period = 0, vs_fall_t = 0, vs_low = 0;

    always @(negedge Clk) begin
        if (hs_p && TFT_HS === 1'b0) begin
            hs_period = cyc - hs_fall_t;
            hs_fall_t = cyc;
        end
        if (!hs_p && TFT_HS === 1'b1) hs_low = cyc - hs_fall_t;
        if (vs_p && TFT_VS === 1'b0) vs_fall_t = cyc;
        if (!vs_p && TFT_VS === 1'b1) vs_low = cyc - vs_fall_t;
        hs_p = TFT_HS;
        vs_p = TFT_VS;
    end

    logic [15:0] line_px [640];
    int de_w = 0, de_rise_t = 0, hs_to_de = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (Bit) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (Bit) @(negedge Clk);
        end
        uart_rx = stop;
        repeat (Bit) @(negedge Clk);
        uart_rx = 1'b1;
        repeat (Bit) @(negedge Clk);
    endtask

    // Records one DE-high line, one sample per pixel (2 Clk each).
    task automatic capture_line();
        int t;
        t = 0;
        while (TFT_DE === 1'b1 && t < 2000) begin
            @(negedge Clk);
            t++;
        end
        t = 0;
        while (TFT_DE !== 1'b1 && t < 70000) begin
            @(negedge Clk);
            t++;
        end
        de_rise_t = cyc;
        hs_to_de  = cyc - hs_fall_t;
        de_w      = 0;
        while (TFT_DE === 1'b1 && de_w < 2000) begin
            if (de_w % 2 == 0 && de_w / 2 < 640) line_px[de_w/2] = TFT_RGB;
            @(negedge Clk);
            de_w++;
        end
    endtask

    logic [7:0] img [17] = '{8'h00, 8'h03, 8'hE0, 8'hFF, 8'h92, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                             8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1C};

    initial begin
        Reset = 1'b1;
        repeat (10) @(negedge Clk);
        check("rst_rgb", TFT_RGB, 16'h0000);
        check("rst_hs", TFT_HS, 1'b1);
        check("rst_vs", TFT_VS, 1'b1);
        check("rst_de", TFT_DE, 1'b0);
        check("rst_clk", TFT_CLK, 1'b0);
        check("rst_bl", TFT_BL, 1'b0);

        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        check("bl_on", TFT_BL, 1'b1);
        check("tclk_low", TFT_CLK, 1'b0);
        @(negedge Clk);
        check("tclk_high", TFT_CLK, 1'b1);

        // Abort a byte halfway through its data bits; it must never be written.
        uart_rx = 1'b0;
        repeat (5 * Bit) @(negedge Clk);
        Reset = 1'b1;
        uart_rx = 1'b1;
        repeat (10) @(negedge Clk);
        Reset = 1'b0;

        send_byte(img[0], 1'b1);
        send_byte(img[1], 1'b1);
        send_byte(8'h55, 1'b0);
        for (int i = 2; i < 17; i++) send_byte(img[i], 1'b1);

        capture_line();
        check("de_width", de_w, 1280);
        check("hs_to_de", hs_to_de, 288);
        check("vs_to_de", de_rise_t - vs_fall_t, 56288);
        check("hs_low", hs_low, 192);
        check("hs_period", hs_period, 1600);
        check("vs_low", vs_low, 3200);
        check("px_0_0_wrap", line_px[0], 16'h07E0);
        check("px_1_0", line_px[1], 16'h001F);
        check("px_2_0_after_ferr", line_px[2], 16'hF800);
        check("px_3_0", line_px[3], 16'hFFFF);
        check("px_4_0_outside", line_px[4], BgX4);
        check("px_100_0_outside", line_px[100], BgX100);

        capture_line();
        check("px_0_1", line_px[0], 16'h9495);
        check("px_1_1", line_px[1], 16'hFFFF);
        capture_line();
        capture_line();
        capture_line();
        check("px_0_4_outside", line_px[0], BgX4);
        check("de_width_row4", de_w, 1280);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
